cache_nway: RTL and testbench
=============================

Name: cache_nway

Overview:
- Parametrised N-way set-associative cache storage with tag compare, per-line valid/dirty state, per-set tree-PLRU replacement and a hardware flush sequencer.
- Successor to the fixed 4-way data/tag array.
- Sits under the AXI cache controller. The controller issues lookups, fills (tag write plus data write) and flushes, and receives hit, victim and line state one cycle later.

Parameters:
- NUM_WAYS, 4, number of ways; power of two, at least 2.
- CACHE_ADDR_WIDTH, 7, byte address width.
- CACHE_DATA_WIDTH, 32, word width in bits.
- CACHE_DATA_SIZE_BYTES, 4, CACHE_DATA_WIDTH/8; power of two.
- CACHE_TAG_WIDTH, 4, tag width.
- NUM_SETS (derived), 2^(CACHE_ADDR_WIDTH - log2(CACHE_DATA_SIZE_BYTES)), default 32.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_cache_addr  in  CACHE_ADDR_WIDTH  byte address; set index = addr >> log2(CACHE_DATA_SIZE_BYTES); low bits ignored.
- i_way_select  in  NUM_WAYS  one-hot write way.
- i_cache_wen  in  1  data write.
- i_cache_ben  in  CACHE_DATA_SIZE_BYTES  byte enables.
- i_cache_data  in  CACHE_DATA_WIDTH  write data.
- i_tag_wen  in  1  tag write (fill).
- i_tag_data  in  CACHE_TAG_WIDTH  tag to write.
- i_lookup  in  1  lookup request.
- i_lookup_tag  in  CACHE_TAG_WIDTH  tag to compare.
- i_flush  in  1  start invalidate-all.
- o_cache_data  out  NUM_WAYS*CACHE_DATA_WIDTH  per-way data, way 0 in LSBs.
- o_tag_data  out  NUM_WAYS*CACHE_TAG_WIDTH  per-way tags.
- o_valid  out  NUM_WAYS  per-way valid.
- o_dirty  out  NUM_WAYS  per-way dirty.
- o_hit  out  1  lookup hit.
- o_hit_way  out  NUM_WAYS  one-hot hit way; 0 on miss.
- o_hit_data  out  CACHE_DATA_WIDTH  data of the hit way; 0 on miss.
- o_victim_way  out  NUM_WAYS  one-hot replacement choice.
- o_busy  out  1  flush in progress.
- o_flush_done  out  1  single-cycle pulse.

Behaviour:
- Reset:
  - All registered outputs are 0.
  - All valid, dirty and PLRU bits are cleared.
  - Flush FSM goes to IDLE.
  - Data/tag arrays are not reset; read values are don't-care while valid=0.
- Read path:
  - The set at i_cache_addr is read every cycle.
  - o_cache_data, o_tag_data, o_valid and o_dirty are registered: 1-cycle latency.
  - Read during a same-set write returns the old contents (read-first).
- Lookup:
  - i_lookup at cycle t produces o_hit, o_hit_way and o_hit_data at t+1.
  - hit = valid & (tag == i_lookup_tag), at most one way.
  - o_hit and o_hit_way are 0 in any cycle not following a lookup.
- Victim:
  - o_victim_way at t+1 is the lowest-index invalid way if any way is invalid, otherwise the PLRU choice.
  - Uses the set state before any update at t+1.
  - Always one-hot.
- Data write (i_cache_wen):
  - Writes the enabled bytes of the selected way.
  - Sets dirty if the line is valid.
  - Writes with i_way_select not one-hot are ignored.
- Tag write (i_tag_wen):
  - Writes the tag and sets valid=1, dirty=0.
  - If i_cache_wen is asserted the same cycle, dirty is set.
- PLRU:
  - NUM_WAYS-1 bits per set.
  - Node bit 0 means the victim is in the lower half.
  - An access sets each node on the path to point away from the accessed way.
  - Updated at the end of cycle t+1 for a lookup hit at t.
  - Updated at the write edge for a tag write.
  - If both target the same set in the same edge, the tag write wins.
- Flush FSM:
  - IDLE → on i_flush: SWEEP, counter=0, o_busy=1.
  - SWEEP: clears valid, dirty and PLRU of set[counter]; counter increments each cycle.
  - After set NUM_SETS-1 → DONE for one cycle (o_flush_done=1, o_busy=0) → IDLE.
  - While busy: writes and lookups are ignored, o_hit=0, i_flush is ignored.
  - i_flush in IDLE coincident with a write: flush wins.
- Reset mid-flush: FSM returns to IDLE on the next edge, all state is cleared, no o_flush_done.

Decomposition:
- cache_pkg holds:
  - clog2 function.
  - plru_victim(bits) and plru_update(bits, way) functions.
  - Flush state enum (IDLE, SWEEP, DONE).
  - Way one-hot/index conversion functions.
- One sub-module, cache_plru_tree: combinational victim and next-state logic for one set; instantiated once, muxed by set index.

Test Plan:
- Reset, then lookup at addr 0x00 tag 0x3 → t+1: o_hit=0, o_valid=0000, o_victim_way=0001, o_busy=0.
- Tag write way 0100 addr 0x10 tag 0x5; data write ben 1111 0x11223344; data write ben 0011 0xAABBCCDD; lookup tag 0x5 → o_hit=1, o_hit_way=0100, o_hit_data=0x1122CCDD, o_dirty=0100.
- Data write 0xDEADBEEF addr 0x10 way 0100 concurrent with read of 0x10 → next-cycle o_cache_data way2 shows the old value; one cycle later it shows 0xDEADBEEF.
- PLRU at addr 0x20:
  - Fill ways 0,1,2,3 in order → lookup miss shows o_victim_way=0001.
  - Lookup hitting way 0 → next lookup shows o_victim_way=0100.
- Flush with NUM_SETS=32 → o_busy high for exactly 32 cycles, o_flush_done pulses on cycle 33. A write during the sweep has no effect. A subsequent lookup misses with o_valid=0000.
- Reset asserted 5 cycles into a flush → o_busy=0 the next cycle, no o_flush_done pulse, all o_valid=0.

Source files
------------

// File: rtl/cache_nway_pkg.sv
// Shared types and helpers for the N-way cache: flush states, tree-PLRU math, one-hot/index conversion.
package cache_nway_pkg;

  localparam int PLRU_VEC_W = 32;

  typedef enum logic [1:0] {
    FL_IDLE  = 2'd0,
    FL_SWEEP = 2'd1,
    FL_DONE  = 2'd2
  } flush_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Heap-ordered tree: node n has children 2n+1 / 2n+2; a 0 bit sends the victim search low.
  function automatic int plru_victim(input logic [PLRU_VEC_W-1:0] bits, input int num_ways);
    int node;
    node = 0;
    for (int lvl = 0; lvl < 5; lvl++) begin
      if ((1 << lvl) < num_ways) node = 2 * node + 1 + (bits[node[4:0]] ? 1 : 0);
    end
    return node - (num_ways - 1);
  endfunction

  function automatic logic [PLRU_VEC_W-1:0] plru_update(input logic [PLRU_VEC_W-1:0] bits,
                                                        input int way, input int num_ways);
    logic [PLRU_VEC_W-1:0] r;
    int node;
    int levels;
    int dir;
    r      = bits;
    node   = 0;
    levels = clog2(num_ways);
    for (int lvl = 0; lvl < 5; lvl++) begin
      if (lvl < levels) begin
        dir            = (way >> (levels - 1 - lvl)) & 1;
        r[node[4:0]]   = (dir == 0);
        node           = 2 * node + 1 + dir;
      end
    end
    return r;
  endfunction

  function automatic logic [PLRU_VEC_W-1:0] idx_to_onehot(input int idx);
    return PLRU_VEC_W'(1) << idx;
  endfunction

  function automatic int onehot_to_idx(input logic [PLRU_VEC_W-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < PLRU_VEC_W; i++) begin
      if (oh[i]) r = r | i;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_nway_if.sv
// Controller-to-cache bus: request side driven by the controller, registered results returned by the cache.
interface cache_nway_if #(
  parameter int NUM_WAYS              = 4,
  parameter int CACHE_ADDR_WIDTH      = 7,
  parameter int CACHE_DATA_WIDTH      = 32,
  parameter int CACHE_DATA_SIZE_BYTES = 4,
  parameter int CACHE_TAG_WIDTH       = 4
);
  logic [CACHE_ADDR_WIDTH-1:0]          i_cache_addr;
  logic [NUM_WAYS-1:0]                  i_way_select;
  logic                                 i_cache_wen;
  logic [CACHE_DATA_SIZE_BYTES-1:0]     i_cache_ben;
  logic [CACHE_DATA_WIDTH-1:0]          i_cache_data;
  logic                                 i_tag_wen;
  logic [CACHE_TAG_WIDTH-1:0]           i_tag_data;
  logic                                 i_lookup;
  logic [CACHE_TAG_WIDTH-1:0]           i_lookup_tag;
  logic                                 i_flush;
  logic [NUM_WAYS*CACHE_DATA_WIDTH-1:0] o_cache_data;
  logic [NUM_WAYS*CACHE_TAG_WIDTH-1:0]  o_tag_data;
  logic [NUM_WAYS-1:0]                  o_valid;
  logic [NUM_WAYS-1:0]                  o_dirty;
  logic                                 o_hit;
  logic [NUM_WAYS-1:0]                  o_hit_way;
  logic [CACHE_DATA_WIDTH-1:0]          o_hit_data;
  logic [NUM_WAYS-1:0]                  o_victim_way;
  logic                                 o_busy;
  logic                                 o_flush_done;

  modport master (
    output i_cache_addr, i_way_select, i_cache_wen, i_cache_ben, i_cache_data,
           i_tag_wen, i_tag_data, i_lookup, i_lookup_tag, i_flush,
    input  o_cache_data, o_tag_data, o_valid, o_dirty, o_hit, o_hit_way,
           o_hit_data, o_victim_way, o_busy, o_flush_done
  );

  modport slave (
    input  i_cache_addr, i_way_select, i_cache_wen, i_cache_ben, i_cache_data,
           i_tag_wen, i_tag_data, i_lookup, i_lookup_tag, i_flush,
    output o_cache_data, o_tag_data, o_valid, o_dirty, o_hit, o_hit_way,
           o_hit_data, o_victim_way, o_busy, o_flush_done
  );
endinterface

// File: rtl/cache_nway_plru_tree.sv
// Combinational tree-PLRU for one set: victim index and the next state after touching access_way.
module cache_plru_tree
  import cache_nway_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  localparam int WAY_W   = clog2(NUM_WAYS),
  localparam int PB      = NUM_WAYS - 1
) (
  input  logic [PB-1:0]    bits,
  input  logic [WAY_W-1:0] access_way,
  output logic [WAY_W-1:0] victim,
  output logic [PB-1:0]    next_bits
);
  always_comb begin
    victim    = WAY_W'(plru_victim(PLRU_VEC_W'(bits), NUM_WAYS));
    next_bits = PB'(plru_update(PLRU_VEC_W'(bits), int'(access_way), NUM_WAYS));
  end
endmodule

// File: rtl/cache_nway.sv
// N-way set-associative tag/data storage with valid/dirty state, tree-PLRU victim and flush sweeper.
// All results are registered one cycle after the request; same-set writes are read-first.
module cache_nway
  import cache_nway_pkg::*;
#(
  parameter int NUM_WAYS              = 4,
  parameter int CACHE_ADDR_WIDTH      = 7,
  parameter int CACHE_DATA_WIDTH      = 32,
  parameter int CACHE_DATA_SIZE_BYTES = 4,
  parameter int CACHE_TAG_WIDTH       = 4
) (
  input logic         clk,
  input logic         reset,
  cache_nway_if.slave bus
);
  localparam int DW       = CACHE_DATA_WIDTH;
  localparam int TW       = CACHE_TAG_WIDTH;
  localparam int OFF_W    = clog2(CACHE_DATA_SIZE_BYTES);
  localparam int IDX_W    = CACHE_ADDR_WIDTH - OFF_W;
  localparam int NUM_SETS = 1 << IDX_W;
  localparam int WAY_W    = clog2(NUM_WAYS);
  localparam int PB       = NUM_WAYS - 1;

  logic [DW-1:0]       data_mem [NUM_SETS][NUM_WAYS];
  logic [TW-1:0]       tag_mem  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q  [NUM_SETS];
  logic [PB-1:0]       plru_q   [NUM_SETS];

  flush_state_e     state_q;
  logic [IDX_W-1:0] sweep_q;
  logic             hit_pend_q;
  logic [IDX_W-1:0] hit_set_q;
  logic [WAY_W-1:0] hit_idx_q;

  logic [IDX_W-1:0]          set_idx;
  logic                      unused_addr;
  logic                      wr_block, way_ok, data_we, tag_we, lookup_ok;
  logic [WAY_W-1:0]          wr_idx, hit_idx, plru_vic;
  logic [NUM_WAYS-1:0]       hit_vec, inv_vec, vic_oh;
  logic [DW-1:0]             hit_dat;
  logic [NUM_WAYS*DW-1:0]    rd_data;
  logic [NUM_WAYS*TW-1:0]    rd_tag;
  logic [PB-1:0]             fill_plru, hit_plru;

  assign set_idx     = bus.i_cache_addr[CACHE_ADDR_WIDTH-1:OFF_W];
  assign unused_addr = ^bus.i_cache_addr;

  // A flush request in IDLE takes priority over any write in the same cycle.
  assign wr_block  = (state_q == FL_SWEEP) || ((state_q == FL_IDLE) && bus.i_flush);
  assign way_ok    = $onehot(bus.i_way_select) && !wr_block;
  assign data_we   = bus.i_cache_wen && way_ok;
  assign tag_we    = bus.i_tag_wen && way_ok;
  assign lookup_ok = bus.i_lookup && (state_q != FL_SWEEP);
  assign wr_idx    = WAY_W'(onehot_to_idx(PLRU_VEC_W'(bus.i_way_select)));
  assign hit_idx   = WAY_W'(onehot_to_idx(PLRU_VEC_W'(hit_vec)));
  assign hit_plru  = PB'(plru_update(PLRU_VEC_W'(plru_q[hit_set_q]), int'(hit_idx_q), NUM_WAYS));

  always_comb begin
    hit_vec = '0;
    hit_dat = '0;
    rd_data = '0;
    rd_tag  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      rd_data[w*DW +: DW] = data_mem[set_idx][w];
      rd_tag[w*TW +: TW]  = tag_mem[set_idx][w];
      hit_vec[w] = valid_q[set_idx][w] && (tag_mem[set_idx][w] == bus.i_lookup_tag);
      if (hit_vec[w]) hit_dat = hit_dat | data_mem[set_idx][w];
    end
  end

  // Invalid ways are always refilled first, lowest index winning.
  always_comb begin
    inv_vec = ~valid_q[set_idx];
    if (|inv_vec) vic_oh = inv_vec & (~inv_vec + NUM_WAYS'(1));
    else          vic_oh = NUM_WAYS'(idx_to_onehot(int'(plru_vic)));
  end

  cache_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .bits       (plru_q[set_idx]),
    .access_way (wr_idx),
    .victim     (plru_vic),
    .next_bits  (fill_plru)
  );

  always_ff @(posedge clk) begin
    if (data_we) begin
      for (int b = 0; b < CACHE_DATA_SIZE_BYTES; b++) begin
        if (bus.i_cache_ben[b]) data_mem[set_idx][wr_idx][b*8 +: 8] <= bus.i_cache_data[b*8 +: 8];
      end
    end
    if (tag_we) tag_mem[set_idx][wr_idx] <= bus.i_tag_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= FL_IDLE;
      sweep_q          <= '0;
      hit_pend_q       <= 1'b0;
      hit_set_q        <= '0;
      hit_idx_q        <= '0;
      bus.o_cache_data <= '0;
      bus.o_tag_data   <= '0;
      bus.o_valid      <= '0;
      bus.o_dirty      <= '0;
      bus.o_hit        <= 1'b0;
      bus.o_hit_way    <= '0;
      bus.o_hit_data   <= '0;
      bus.o_victim_way <= '0;
      bus.o_busy       <= 1'b0;
      bus.o_flush_done <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      bus.o_cache_data <= rd_data;
      bus.o_tag_data   <= rd_tag;
      bus.o_valid      <= valid_q[set_idx];
      bus.o_dirty      <= dirty_q[set_idx];
      bus.o_hit        <= lookup_ok && (|hit_vec);
      bus.o_hit_way    <= lookup_ok ? hit_vec : '0;
      bus.o_hit_data   <= lookup_ok ? hit_dat : '0;
      bus.o_victim_way <= vic_oh;

      // Hit touches land one cycle late; a same-set fill below overrides them.
      hit_pend_q <= lookup_ok && (|hit_vec);
      hit_set_q  <= set_idx;
      hit_idx_q  <= hit_idx;
      if (hit_pend_q) plru_q[hit_set_q] <= hit_plru;

      if (data_we && valid_q[set_idx][wr_idx]) dirty_q[set_idx][wr_idx] <= 1'b1;
      if (tag_we) begin
        valid_q[set_idx][wr_idx] <= 1'b1;
        dirty_q[set_idx][wr_idx] <= data_we;
        plru_q[set_idx]          <= fill_plru;
      end

      case (state_q)
        FL_IDLE: begin
          if (bus.i_flush) begin
            state_q    <= FL_SWEEP;
            sweep_q    <= '0;
            bus.o_busy <= 1'b1;
          end
        end
        FL_SWEEP: begin
          valid_q[sweep_q] <= '0;
          dirty_q[sweep_q] <= '0;
          plru_q[sweep_q]  <= '0;
          if (sweep_q == IDX_W'(NUM_SETS - 1)) begin
            state_q          <= FL_DONE;
            bus.o_busy       <= 1'b0;
            bus.o_flush_done <= 1'b1;
          end else begin
            sweep_q <= sweep_q + IDX_W'(1);
          end
        end
        FL_DONE: begin
          state_q          <= FL_IDLE;
          bus.o_flush_done <= 1'b0;
        end
        default: state_q <= FL_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: a per-set behavioural model checked every cycle plus literal checkpoints.
module tb_cache_nway;
  localparam int NW = 4;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int BY = 4;
  localparam int TW = 4;
  localparam int NS = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_nway_if #(.NUM_WAYS(NW), .CACHE_ADDR_WIDTH(AW), .CACHE_DATA_WIDTH(DW),
                  .CACHE_DATA_SIZE_BYTES(BY), .CACHE_TAG_WIDTH(TW)) bus ();

  cache_nway #(.NUM_WAYS(NW), .CACHE_ADDR_WIDTH(AW), .CACHE_DATA_WIDTH(DW),
               .CACHE_DATA_SIZE_BYTES(BY), .CACHE_TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: plain per-set arrays; PLRU kept as a root choice plus one choice per way pair.
  logic          m_valid [NS][NW];
  logic          m_dirty [NS][NW];
  logic [TW-1:0] m_tag   [NS][NW];
  logic [DW-1:0] m_data  [NS][NW];
  logic          m_root  [NS];
  logic          m_pair  [NS][2];
  int            fl_age;
  bit            pend;
  int            pend_set, pend_way;
  bit            model_ok = 1'b0;

  logic [DW-1:0] e_data [NW];
  logic [TW-1:0] e_tag  [NW];
  logic [NW-1:0] e_valid, e_dirty, e_hit_way, e_victim;
  logic          e_hit, e_busy, e_done;
  logic [DW-1:0] e_hit_data;

  task automatic touch(input int s, input int w);
    m_root[s]       = (w < 2);
    m_pair[s][w / 2] = (w % 2 == 0);
  endtask

  task automatic model_step();
    int s;
    int wi;
    bit busy;
    bit lk;
    bit wr_ok;
    bit found;
    logic [NW-1:0] hv;
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        for (int w = 0; w < NW; w++) begin
          m_valid[i][w] = 1'b0;
          m_dirty[i][w] = 1'b0;
        end
        m_root[i]    = 1'b0;
        m_pair[i][0] = 1'b0;
        m_pair[i][1] = 1'b0;
      end
      fl_age = 0;
      pend   = 1'b0;
      e_valid = '0; e_dirty = '0; e_hit = 1'b0; e_hit_way = '0; e_hit_data = '0;
      e_victim = '0; e_busy = 1'b0; e_done = 1'b0;
      model_ok = 1'b1;
      return;
    end
    s    = int'(bus.i_cache_addr) / BY;
    busy = (fl_age >= 1) && (fl_age <= NS);
    for (int w = 0; w < NW; w++) begin
      e_data[w]  = m_data[s][w];
      e_tag[w]   = m_tag[s][w];
      e_valid[w] = m_valid[s][w];
      e_dirty[w] = m_dirty[s][w];
    end
    e_victim = '0;
    found    = 1'b0;
    for (int w = 0; w < NW; w++) begin
      if (!found && !m_valid[s][w]) begin
        e_victim[w] = 1'b1;
        found       = 1'b1;
      end
    end
    if (!found) begin
      if (m_root[s]) e_victim[m_pair[s][1] ? 3 : 2] = 1'b1;
      else           e_victim[m_pair[s][0] ? 1 : 0] = 1'b1;
    end
    lk = bus.i_lookup && !busy;
    hv = '0;
    e_hit_data = '0;
    for (int w = 0; w < NW; w++) begin
      if (lk && m_valid[s][w] && m_tag[s][w] == bus.i_lookup_tag) begin
        hv[w]      = 1'b1;
        e_hit_data = m_data[s][w];
      end
    end
    e_hit     = (hv != '0);
    e_hit_way = hv;

    if (pend) touch(pend_set, pend_way);
    pend = 1'b0;
    if (e_hit) begin
      pend     = 1'b1;
      pend_set = s;
      for (int w = 0; w < NW; w++) if (hv[w]) pend_way = w;
    end

    wr_ok = !busy && !(fl_age == 0 && bus.i_flush) && $onehot(bus.i_way_select);
    if (wr_ok) begin
      wi = 0;
      for (int w = 0; w < NW; w++) if (bus.i_way_select[w]) wi = w;
      if (bus.i_cache_wen) begin
        for (int b = 0; b < BY; b++)
          if (bus.i_cache_ben[b]) m_data[s][wi][8*b +: 8] = bus.i_cache_data[8*b +: 8];
        if (m_valid[s][wi]) m_dirty[s][wi] = 1'b1;
      end
      if (bus.i_tag_wen) begin
        m_tag[s][wi]   = bus.i_tag_data;
        m_valid[s][wi] = 1'b1;
        m_dirty[s][wi] = bus.i_cache_wen;
        touch(s, wi);
      end
    end

    // fl_age counts cycles since the flush was accepted; cycles 1..NS each wipe one set.
    if (fl_age == 0) begin
      if (bus.i_flush) fl_age = 1;
    end else if (fl_age <= NS) begin
      for (int w = 0; w < NW; w++) begin
        m_valid[fl_age-1][w] = 1'b0;
        m_dirty[fl_age-1][w] = 1'b0;
      end
      m_root[fl_age-1]    = 1'b0;
      m_pair[fl_age-1][0] = 1'b0;
      m_pair[fl_age-1][1] = 1'b0;
      fl_age++;
    end else begin
      fl_age = 0;
    end
    e_busy   = (fl_age >= 1) && (fl_age <= NS);
    e_done   = (fl_age == NS + 1);
    model_ok = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk("valid", 32'(bus.o_valid), 32'(e_valid));
      chk("dirty", 32'(bus.o_dirty), 32'(e_dirty));
      chk("hit", 32'(bus.o_hit), 32'(e_hit));
      chk("hit_way", 32'(bus.o_hit_way), 32'(e_hit_way));
      chk("hit_data", bus.o_hit_data, e_hit_data);
      chk("victim", 32'(bus.o_victim_way), 32'(e_victim));
      chk("busy", 32'(bus.o_busy), 32'(e_busy));
      chk("flush_done", 32'(bus.o_flush_done), 32'(e_done));
      for (int w = 0; w < NW; w++) begin
        if (e_valid[w]) begin
          chk("way_data", bus.o_cache_data[w*DW +: DW], e_data[w]);
          chk("way_tag", 32'(bus.o_tag_data[w*TW +: TW]), 32'(e_tag[w]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.i_cache_addr = '0;
    bus.i_way_select = '0;
    bus.i_cache_wen  = 1'b0;
    bus.i_cache_ben  = '0;
    bus.i_cache_data = '0;
    bus.i_tag_wen    = 1'b0;
    bus.i_tag_data   = '0;
    bus.i_lookup     = 1'b0;
    bus.i_lookup_tag = '0;
    bus.i_flush      = 1'b0;
  endtask

  task automatic op_tag(input logic [AW-1:0] a, input logic [NW-1:0] way, input logic [TW-1:0] tg);
    bus.i_cache_addr = a; bus.i_way_select = way; bus.i_tag_wen = 1'b1; bus.i_tag_data = tg;
    tick();
    idle_in();
  endtask

  task automatic op_data(input logic [AW-1:0] a, input logic [NW-1:0] way,
                         input logic [BY-1:0] ben, input logic [DW-1:0] d);
    bus.i_cache_addr = a; bus.i_way_select = way; bus.i_cache_wen = 1'b1;
    bus.i_cache_ben = ben; bus.i_cache_data = d;
    tick();
    idle_in();
  endtask

  task automatic op_lookup(input logic [AW-1:0] a, input logic [TW-1:0] tg);
    bus.i_cache_addr = a; bus.i_lookup = 1'b1; bus.i_lookup_tag = tg;
    tick();
    idle_in();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    int done_at;
    int done_cnt;
    idle_in();
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_busy", 32'(bus.o_busy), 32'h0);
    chk("rst_victim", 32'(bus.o_victim_way), 32'h0);
    chk("rst_hit", 32'(bus.o_hit), 32'h0);
    reset = 1'b0;

    op_lookup(7'h00, 4'h3);
    chk("t1_hit", 32'(bus.o_hit), 32'h0);
    chk("t1_valid", 32'(bus.o_valid), 32'h0);
    chk("t1_victim", 32'(bus.o_victim_way), 32'h1);
    chk("t1_busy", 32'(bus.o_busy), 32'h0);

    op_tag(7'h10, 4'b0100, 4'h5);
    op_data(7'h10, 4'b0100, 4'b1111, 32'h11223344);
    op_data(7'h10, 4'b0100, 4'b0011, 32'hAABBCCDD);
    op_lookup(7'h10, 4'h5);
    chk("t2_hit", 32'(bus.o_hit), 32'h1);
    chk("t2_hit_way", 32'(bus.o_hit_way), 32'h4);
    chk("t2_hit_data", bus.o_hit_data, 32'h1122CCDD);
    chk("t2_dirty", 32'(bus.o_dirty), 32'h4);
    chk("t2_valid", 32'(bus.o_valid), 32'h4);

    op_data(7'h10, 4'b0100, 4'b1111, 32'hDEADBEEF);
    chk("t3_read_first", bus.o_cache_data[95:64], 32'h1122CCDD);
    bus.i_cache_addr = 7'h10;
    tick();
    idle_in();
    chk("t3_new_data", bus.o_cache_data[95:64], 32'hDEADBEEF);

    op_tag(7'h20, 4'b0001, 4'h1);
    op_tag(7'h20, 4'b0010, 4'h2);
    op_tag(7'h20, 4'b0100, 4'h3);
    op_tag(7'h20, 4'b1000, 4'h4);
    op_lookup(7'h20, 4'hF);
    chk("t4_miss", 32'(bus.o_hit), 32'h0);
    chk("t4_full", 32'(bus.o_valid), 32'hF);
    chk("t4_victim_a", 32'(bus.o_victim_way), 32'h1);
    op_lookup(7'h20, 4'h1);
    chk("t4_hit_way0", 32'(bus.o_hit_way), 32'h1);
    tick();
    op_lookup(7'h20, 4'hF);
    chk("t4_victim_b", 32'(bus.o_victim_way), 32'h4);

    bus.i_flush = 1'b1;
    tick();
    idle_in();
    busy_cnt = 0;
    done_at  = -1;
    for (int i = 1; i <= 60 && done_at < 0; i++) begin
      if (bus.o_busy) busy_cnt++;
      if (bus.o_flush_done) done_at = i;
      idle_in();
      if (i == 10) begin
        bus.i_cache_addr = 7'h08; bus.i_way_select = 4'b0001; bus.i_tag_wen = 1'b1;
        bus.i_tag_data = 4'h7; bus.i_cache_wen = 1'b1; bus.i_cache_ben = 4'hF;
        bus.i_cache_data = 32'h55;
      end
      tick();
    end
    idle_in();
    chk("t5_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("t5_done_cycle", 32'(done_at), 32'd33);
    op_lookup(7'h08, 4'h7);
    chk("t5_sweep_write_hit", 32'(bus.o_hit), 32'h0);
    chk("t5_sweep_write_valid", 32'(bus.o_valid), 32'h0);
    op_lookup(7'h10, 4'h5);
    chk("t5_flushed_hit", 32'(bus.o_hit), 32'h0);
    chk("t5_flushed_valid", 32'(bus.o_valid), 32'h0);

    op_tag(7'h30, 4'b0001, 4'h9);
    bus.i_flush = 1'b1;
    tick();
    idle_in();
    repeat (4) tick();
    reset = 1'b1;
    bus.i_cache_addr = 7'h30;
    tick();
    chk("t6_busy", 32'(bus.o_busy), 32'h0);
    chk("t6_done", 32'(bus.o_flush_done), 32'h0);
    chk("t6_valid", 32'(bus.o_valid), 32'h0);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      bus.i_cache_addr = 7'h30;
      tick();
      if (bus.o_flush_done) done_cnt++;
    end
    chk("t6_no_done_pulse", 32'(done_cnt), 32'h0);
    chk("t6_valid_after", 32'(bus.o_valid), 32'h0);
    idle_in();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
